// File: rtl/cpu_int_arbiter_if.sv
// Interrupt arbiter bus: CPU-side controls, peripheral lines and request/vector results.
// The master side drives the controls and lines; the arbiter is the slave.
interface cpu_int_arbiter_if #(
  parameter int unsigned NUM_SRC = 4
);
  logic               ce;
  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] mask;
  logic               inh;
  logic               sample;
  logic               vec_fetch;
  logic               vec_hi;
  logic               int_req;
  logic               int_is_rst;
  logic [2:0]         int_id;
  logic [15:0]        vec_addr;
  logic [NUM_SRC-1:0] pending;

  modport master (
    output ce, src_in, edge_mode, mask, inh, sample, vec_fetch, vec_hi,
    input  int_req, int_is_rst, int_id, vec_addr, pending
  );

  modport slave (
    input  ce, src_in, edge_mode, mask, inh, sample, vec_fetch, vec_hi,
    output int_req, int_is_rst, int_id, vec_addr, pending
  );
endinterface

// File: rtl/cpu_int_arbiter.sv
// Fixed-priority interrupt front-end for the 6502-style core: latches edge/level sources,
// reports the winner at the CPU check point and supplies its vector during vector fetch.
module cpu_int_arbiter #(
  parameter int unsigned        NUM_SRC  = 4,
  parameter logic [NUM_SRC-1:0] NONMASK  = NUM_SRC'(1),
  parameter logic [15:0]        VEC_BASE = 16'hFFF0,
  parameter logic [15:0]        RST_VEC  = 16'hFFFC
) (
  input logic              clk,
  input logic              reset,
  cpu_int_arbiter_if.slave bus
);
  localparam int unsigned ID_W = 3;

  logic [NUM_SRC-1:0] history;
  logic [NUM_SRC-1:0] pendingQ;
  logic [NUM_SRC-1:0] enabled;
  logic               intReq;
  logic               intIsRst;
  logic [ID_W-1:0]    intId;
  logic [ID_W-1:0]    winner;
  logic               found;
  logic               edgeQual;
  logic               vecClr;

  // Edges are neither latched nor tracked while a vector is fetched or reset is in progress,
  // so an edge arriving then is still seen once the window closes.
  assign edgeQual = ~bus.vec_fetch & ~intIsRst;
  assign vecClr   = bus.vec_fetch & ~bus.vec_hi & ~intIsRst;

  // Lowest enabled index wins; the previous id is kept when nothing is enabled.
  always_comb begin
    enabled = pendingQ & bus.mask & ~({NUM_SRC{bus.inh}} & ~NONMASK);
    winner  = intId;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (enabled[i] && !found) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      intReq   <= 1'b1;
      intIsRst <= 1'b1;
      intId    <= '0;
      pendingQ <= '0;
      history  <= '0;
    end else if (bus.ce) begin
      if (bus.sample) begin
        intReq   <= found;
        intId    <= winner;
        intIsRst <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!bus.edge_mode[i]) begin
          pendingQ[i] <= bus.src_in[i];
        end else if (edgeQual && bus.src_in[i] && !history[i]) begin
          pendingQ[i] <= 1'b1;
        end else if (vecClr && intId == ID_W'(i)) begin
          pendingQ[i] <= 1'b0;
        end
        if (edgeQual) begin
          history[i] <= bus.src_in[i];
        end
      end
    end
  end

  assign bus.int_req    = intReq;
  assign bus.int_is_rst = intIsRst;
  assign bus.int_id     = intId;
  assign bus.pending    = pendingQ;
  assign bus.vec_addr   = intIsRst ? RST_VEC + 16'(bus.vec_hi)
                                   : VEC_BASE + 16'({intId, 1'b0}) + 16'(bus.vec_hi);
endmodule

// File: tb/tb_cpu_int_arbiter.sv
// Scenario bench for cpu_int_arbiter: sample results are queued when requested and
// compared when the registered request appears; vectors and pending bits are checked inline.
module tb_cpu_int_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_int_arbiter_if #(.NUM_SRC(4)) bus ();

  cpu_int_arbiter #(
    .NUM_SRC (4),
    .NONMASK (4'b0001),
    .VEC_BASE(16'hFFF0),
    .RST_VEC (16'hFFFC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       req;
    logic       isRst;
    logic [2:0] id;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   nChecks = 0;
  int   nFails  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected outcome, then pulse the check point for one cycle.
  task automatic do_sample(input logic req, input logic [2:0] id);
    exp_t x;
    x.req   = req;
    x.isRst = 1'b0;
    x.id    = id;
    sb.push_back(x);
    bus.sample = 1'b1;
    tick();
    bus.sample = 1'b0;
  endtask

  task automatic pulse_src(input int idx);
    bus.src_in[idx] = 1'b1;
    tick();
    bus.src_in[idx] = 1'b0;
  endtask

  task automatic set_vec(input logic fetch, input logic hi);
    bus.vec_fetch = fetch;
    bus.vec_hi    = hi;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    nChecks++;
    if ({bus.int_req, bus.int_is_rst, bus.int_id} !== {1'b1, 1'b1, 3'd0}) begin
      nFails++;
      $display("FAIL reset_regs: req/rst/id=%b/%b/%0d expected 1/1/0", bus.int_req, bus.int_is_rst, bus.int_id);
    end
    nChecks++;
    if (bus.pending !== 4'b0000) begin
      nFails++;
      $display("FAIL reset_pending: got %b expected 0000", bus.pending);
    end
    set_vec(1'b1, 1'b0);
    nChecks++;
    if (bus.vec_addr !== 16'hFFFC) begin
      nFails++;
      $display("FAIL reset_vec_lo: got %h expected fffc", bus.vec_addr);
    end
    tick();
    set_vec(1'b1, 1'b1);
    nChecks++;
    if (bus.vec_addr !== 16'hFFFD) begin
      nFails++;
      $display("FAIL reset_vec_hi: got %h expected fffd", bus.vec_addr);
    end
    tick();
    set_vec(1'b0, 1'b0);
    do_sample(1'b0, 3'd0);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_is_rst, bus.int_id} !== {e.req, e.isRst, e.id}) begin
      nFails++;
      $display("FAIL reset_exit: req/rst/id=%b/%b/%0d expected %b/%b/%0d",
               bus.int_req, bus.int_is_rst, bus.int_id, e.req, e.isRst, e.id);
    end
  endtask

  task automatic test_edge();
    pulse_src(0);
    nChecks++;
    if (bus.pending !== 4'b0001) begin
      nFails++;
      $display("FAIL edge_latch: pending=%b expected 0001", bus.pending);
    end
    do_sample(1'b1, 3'd0);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_is_rst, bus.int_id} !== {e.req, e.isRst, e.id}) begin
      nFails++;
      $display("FAIL edge_sample: req/rst/id=%b/%b/%0d expected %b/%b/%0d",
               bus.int_req, bus.int_is_rst, bus.int_id, e.req, e.isRst, e.id);
    end
    set_vec(1'b1, 1'b0);
    nChecks++;
    if (bus.vec_addr !== 16'hFFF0) begin
      nFails++;
      $display("FAIL edge_vec_lo: got %h expected fff0", bus.vec_addr);
    end
    tick();
    set_vec(1'b1, 1'b1);
    nChecks++;
    if (bus.vec_addr !== 16'hFFF1 || bus.pending !== 4'b0000) begin
      nFails++;
      $display("FAIL edge_vec_hi: vec=%h pending=%b expected fff1/0000", bus.vec_addr, bus.pending);
    end
    tick();
    set_vec(1'b0, 1'b0);
  endtask

  task automatic test_priority();
    bus.src_in = 4'b0101;
    tick();
    bus.src_in[0] = 1'b0;
    nChecks++;
    if (bus.pending !== 4'b0101) begin
      nFails++;
      $display("FAIL prio_pending: got %b expected 0101", bus.pending);
    end
    do_sample(1'b1, 3'd0);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id} !== {e.req, e.id}) begin
      nFails++;
      $display("FAIL prio_first: req/id=%b/%0d expected %b/%0d", bus.int_req, bus.int_id, e.req, e.id);
    end
    set_vec(1'b1, 1'b0);
    tick();
    set_vec(1'b1, 1'b1);
    tick();
    set_vec(1'b0, 1'b0);
    do_sample(1'b1, 3'd2);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id} !== {e.req, e.id}) begin
      nFails++;
      $display("FAIL prio_second: req/id=%b/%0d expected %b/%0d", bus.int_req, bus.int_id, e.req, e.id);
    end
    set_vec(1'b1, 1'b0);
    nChecks++;
    if (bus.vec_addr !== 16'hFFF4) begin
      nFails++;
      $display("FAIL prio_vec2: got %h expected fff4", bus.vec_addr);
    end
    tick();
    set_vec(1'b1, 1'b1);
    nChecks++;
    if (bus.vec_addr !== 16'hFFF5 || bus.pending !== 4'b0100) begin
      nFails++;
      $display("FAIL prio_level_kept: vec=%h pending=%b expected fff5/0100", bus.vec_addr, bus.pending);
    end
    tick();
    set_vec(1'b0, 1'b0);
    bus.src_in[2] = 1'b0;
    tick();
    do_sample(1'b0, 3'd2);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id} !== {e.req, e.id}) begin
      nFails++;
      $display("FAIL level_lost: req/id=%b/%0d expected %b/%0d", bus.int_req, bus.int_id, e.req, e.id);
    end
  endtask

  task automatic test_inhibit();
    bus.edge_mode = 4'b1001;
    bus.inh       = 1'b1;
    bus.src_in[1] = 1'b1;
    tick();
    do_sample(1'b0, 3'd2);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id, bus.pending} !== {e.req, e.id, 4'b0010}) begin
      nFails++;
      $display("FAIL inh_blocks: req/id/pend=%b/%0d/%b expected %b/%0d/0010",
               bus.int_req, bus.int_id, bus.pending, e.req, e.id);
    end
    pulse_src(0);
    do_sample(1'b1, 3'd0);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id} !== {e.req, e.id}) begin
      nFails++;
      $display("FAIL inh_nmi: req/id=%b/%0d expected %b/%0d", bus.int_req, bus.int_id, e.req, e.id);
    end
    set_vec(1'b1, 1'b0);
    tick();
    set_vec(1'b1, 1'b1);
    tick();
    set_vec(1'b0, 1'b0);
    bus.src_in[1] = 1'b0;
    bus.inh       = 1'b0;
    tick();
    bus.edge_mode = 4'b1011;
    tick();
  endtask

  task automatic test_vec_fetch_edge();
    bus.src_in[0] = 1'b1;
    set_vec(1'b1, 1'b0);
    tick();
    set_vec(1'b1, 1'b1);
    tick();
    nChecks++;
    if (bus.pending[0] !== 1'b0) begin
      nFails++;
      $display("FAIL fetch_no_latch: pending[0]=%b expected 0", bus.pending[0]);
    end
    set_vec(1'b0, 1'b0);
    tick();
    bus.src_in[0] = 1'b0;
    nChecks++;
    if (bus.pending[0] !== 1'b1) begin
      nFails++;
      $display("FAIL fetch_late_latch: pending[0]=%b expected 1", bus.pending[0]);
    end
    do_sample(1'b1, 3'd0);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id} !== {e.req, e.id}) begin
      nFails++;
      $display("FAIL fetch_sample: req/id=%b/%0d expected %b/%0d", bus.int_req, bus.int_id, e.req, e.id);
    end
    set_vec(1'b1, 1'b0);
    tick();
    set_vec(1'b1, 1'b1);
    tick();
    set_vec(1'b0, 1'b0);
  endtask

  task automatic test_masked_ce();
    bus.mask = 4'b0111;
    pulse_src(3);
    nChecks++;
    if (bus.pending !== 4'b1000) begin
      nFails++;
      $display("FAIL mask_latch: pending=%b expected 1000", bus.pending);
    end
    do_sample(1'b0, 3'd0);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id} !== {e.req, e.id}) begin
      nFails++;
      $display("FAIL mask_hidden: req/id=%b/%0d expected %b/%0d", bus.int_req, bus.int_id, e.req, e.id);
    end
    repeat (3) tick();
    bus.ce        = 1'b0;
    bus.src_in[0] = 1'b1;
    bus.sample    = 1'b1;
    bus.mask      = 4'b1111;
    tick();
    tick();
    bus.src_in[0] = 1'b0;
    bus.sample    = 1'b0;
    bus.mask      = 4'b0111;
    nChecks++;
    if ({bus.int_req, bus.int_id, bus.pending} !== {1'b0, 3'd0, 4'b1000}) begin
      nFails++;
      $display("FAIL ce_freeze: req/id/pend=%b/%0d/%b expected 0/0/1000", bus.int_req, bus.int_id, bus.pending);
    end
    bus.ce = 1'b1;
    repeat (3) tick();
    bus.mask = 4'b1111;
    do_sample(1'b1, 3'd3);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id} !== {e.req, e.id}) begin
      nFails++;
      $display("FAIL mask_enable: req/id=%b/%0d expected %b/%0d", bus.int_req, bus.int_id, e.req, e.id);
    end
    set_vec(1'b1, 1'b0);
    nChecks++;
    if (bus.vec_addr !== 16'hFFF6) begin
      nFails++;
      $display("FAIL mask_vec_lo: got %h expected fff6", bus.vec_addr);
    end
    tick();
    set_vec(1'b1, 1'b1);
    nChecks++;
    if (bus.vec_addr !== 16'hFFF7 || bus.pending !== 4'b0000) begin
      nFails++;
      $display("FAIL mask_vec_hi: vec=%h pending=%b expected fff7/0000", bus.vec_addr, bus.pending);
    end
    tick();
    set_vec(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    pulse_src(1);
    do_sample(1'b1, 3'd1);
    e = sb.pop_front();
    nChecks++;
    if ({bus.int_req, bus.int_id} !== {e.req, e.id}) begin
      nFails++;
      $display("FAIL rstmid_sample: req/id=%b/%0d expected %b/%0d", bus.int_req, bus.int_id, e.req, e.id);
    end
    set_vec(1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nChecks++;
    if ({bus.int_req, bus.int_is_rst, bus.int_id, bus.pending, bus.vec_addr} !==
        {1'b1, 1'b1, 3'd0, 4'b0000, 16'hFFFC}) begin
      nFails++;
      $display("FAIL rstmid_state: req/rst/id/pend/vec=%b/%b/%0d/%b/%h expected 1/1/0/0000/fffc",
               bus.int_req, bus.int_is_rst, bus.int_id, bus.pending, bus.vec_addr);
    end
    set_vec(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.ce        = 1'b1;
    bus.src_in    = 4'b0000;
    bus.edge_mode = 4'b1011;
    bus.mask      = 4'b0111;
    bus.inh       = 1'b0;
    bus.sample    = 1'b0;
    bus.vec_fetch = 1'b0;
    bus.vec_hi    = 1'b0;
    test_reset();
    test_edge();
    test_priority();
    test_inhibit();
    test_vec_fetch_edge();
    test_masked_ce();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
